// File: rtl/gate_lab_pkg.sv
// Shared types and constants for the gate lab: op codes, FSM states, lane width
// and the legal pipeline depth range.
package gate_lab_pkg;

   localparam int LANE_W         = 4;
   localparam int PIPE_DEPTH_MIN = 1;
   localparam int PIPE_DEPTH_MAX = 4;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_ANDN = 3'd6,
      OP_PASS = 3'd7
   } op_e;

   typedef enum logic {
      ST_FLUSH = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   function automatic logic [LANE_W-1:0] gate_eval(input op_e op,
                                                   input logic [LANE_W-1:0] a,
                                                   input logic [LANE_W-1:0] b);
      logic [LANE_W-1:0] r;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NAND: r = ~(a & b);
         OP_NOR:  r = ~(a | b);
         OP_XNOR: r = ~(a ^ b);
         OP_ANDN: r = a & ~b;
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/gate_lab_pipe.sv
// Enabled delay line of DEPTH registers; dout is the oldest stage. All stages
// hold while ena is low.
module gate_lab_pipe #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];

   always_comb begin
      for (int i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
      if (ena) begin
         stage_d[0] = din;
         for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/tt_um_gate_lab.sv
// Selectable 4-lane bitwise gate with a strobe-loaded op register, pipelined
// result, flush/run qualifier and a saturating all-ones match counter.
module tt_um_gate_lab
   import gate_lab_pkg::*;
#(
   parameter int PIPE_DEPTH = 2,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [2:0] FLUSH_LAST = 3'(PIPE_DEPTH - 1);

   logic [LANE_W-1:0] a, b, gate_res, tail;
   logic              strb_edge;

   // [0] first sync flop, [1] synchronised strobe, [2] delayed copy for edge detect
   logic [2:0]       strb_sync_q, strb_sync_d;
   logic [2:0]       op_sync1_q, op_sync1_d;
   logic [2:0]       op_sync2_q, op_sync2_d;
   op_e              op_reg_q, op_reg_d;
   state_e           state_q, state_d;
   logic [2:0]       flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

   logic unused_uio_hi;
   assign unused_uio_hi = &{1'b0, uio_in[7:4]};

   assign a         = ui_in[3:0];
   assign b         = ui_in[7:4];
   assign strb_edge = strb_sync_q[1] & ~strb_sync_q[2];
   assign gate_res  = gate_eval(op_reg_q, a, b);

   always_comb begin
      strb_sync_d = strb_sync_q;
      op_sync1_d  = op_sync1_q;
      op_sync2_d  = op_sync2_q;
      op_reg_d    = op_reg_q;
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      match_cnt_d = match_cnt_q;
      if (ena) begin
         strb_sync_d = {strb_sync_q[1:0], uio_in[3]};
         op_sync1_d  = uio_in[2:0];
         op_sync2_d  = op_sync1_q;
         if (strb_edge) begin
            // New op invalidates everything in flight: restart flush, drop count
            op_reg_d    = op_e'(op_sync2_q);
            state_d     = ST_FLUSH;
            flush_cnt_d = '0;
            match_cnt_d = '0;
         end else if (state_q == ST_FLUSH) begin
            if (flush_cnt_q == FLUSH_LAST) begin
               state_d     = ST_RUN;
               flush_cnt_d = '0;
            end else begin
               flush_cnt_d = flush_cnt_q + 3'd1;
            end
         end else if (tail == 4'hF && !(&match_cnt_q)) begin
            match_cnt_d = match_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strb_sync_q <= '0;
         op_sync1_q  <= '0;
         op_sync2_q  <= '0;
         op_reg_q    <= OP_AND;
         state_q     <= ST_FLUSH;
         flush_cnt_q <= '0;
         match_cnt_q <= '0;
      end else begin
         strb_sync_q <= strb_sync_d;
         op_sync1_q  <= op_sync1_d;
         op_sync2_q  <= op_sync2_d;
         op_reg_q    <= op_reg_d;
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         match_cnt_q <= match_cnt_d;
      end
   end

   gate_lab_pipe #(
      .WIDTH(LANE_W),
      .DEPTH(PIPE_DEPTH)
   ) u_pipe (
      .clk  (clk),
      .rst_n(rst_n),
      .ena  (ena),
      .din  (gate_res),
      .dout (tail)
   );

   assign uo_out  = {match_cnt_q, tail};
   assign uio_out = {(state_q == ST_RUN), op_reg_q, 4'h0};
   assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_gate_lab.sv
// Scoreboard bench for tt_um_gate_lab: a cycle model pushes expected outputs per
// driven cycle, popped and compared one edge later, plus directed spot checks.
module tb_tt_um_gate_lab;

   localparam int PD = 2;

   typedef struct packed {
      logic [7:0] uo;
      logic [7:0] uio;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [3:0] a, b;
   logic [2:0] op;
   logic       strb;
   logic [3:0] uio_hi;
   logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

   assign ui_in  = {b, a};
   assign uio_in = {uio_hi, strb, op};

   tt_um_gate_lab #(.PIPE_DEPTH(PD), .CNT_W(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .ui_in  (ui_in),
      .uio_in (uio_in),
      .uo_out (uo_out),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t exp_q[$];

   // Reference model state
   logic       m_s1, m_s2, m_s3;
   logic [2:0] m_op1, m_op2, m_op;
   logic [3:0] m_pipe [PD];
   logic       m_run;
   int         m_fc;
   logic [3:0] m_cnt;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h, want %02h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [3:0] ref_gate(input logic [2:0] o, input logic [3:0] x,
                                           input logic [3:0] y);
      case (o)
         3'd0:    return x & y;
         3'd1:    return x | y;
         3'd2:    return x ^ y;
         3'd3:    return ~(x & y);
         3'd4:    return ~(x | y);
         3'd5:    return ~(x ^ y);
         3'd6:    return x & ~y;
         default: return x;
      endcase
   endfunction

   task automatic m_reset();
      m_s1 = 0; m_s2 = 0; m_s3 = 0;
      m_op1 = 0; m_op2 = 0; m_op = 0;
      for (int i = 0; i < PD; i++) m_pipe[i] = 4'h0;
      m_run = 0; m_fc = 0; m_cnt = 4'h0;
   endtask

   task automatic m_update();
      logic       edge_det;
      logic [3:0] res;
      edge_det = m_s2 && !m_s3;
      res      = ref_gate(m_op, a, b);
      if (edge_det) begin
         m_cnt = 4'h0;
         m_run = 0;
         m_fc  = 0;
      end else if (!m_run) begin
         if (m_fc == PD - 1) begin
            m_run = 1;
            m_fc  = 0;
         end else begin
            m_fc++;
         end
      end else if (m_pipe[PD-1] == 4'hF && m_cnt != 4'hF) begin
         m_cnt++;
      end
      if (edge_det) m_op = m_op2;
      for (int i = PD - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = res;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = strb;
      m_op2 = m_op1; m_op1 = op;
   endtask

   task automatic step();
      exp_t e;
      uio_hi = 4'($urandom);
      if (ena) m_update();
      e.uo  = {m_cnt, m_pipe[PD-1]};
      e.uio = {m_run, m_op, 4'h0};
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("uo_out", uo_out, e.uo);
      chk("uio_out", uio_out, e.uio);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // One-cycle strobe; the op register loads on the third edge
   task automatic strobe_pulse(input logic [2:0] new_op);
      op   = new_op;
      strb = 1'b1;
      step();
      strb = 1'b0;
      step();
      step();
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; a = 4'h0; b = 4'h0; op = 3'd0; strb = 1'b0; uio_hi = 4'h0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_uo", uo_out, 8'h00);
      chk("rst_uio", uio_out, 8'h00);
      chk("rst_oe", uio_oe, 8'hF0);
      rst_n = 1'b1;

      // Default AND gate after reset
      a = 4'hC; b = 4'hA;
      step();
      chk("and_valid_early", {7'h0, uio_out[7]}, 8'h00);
      step();
      chk("and_res", {4'h0, uo_out[3:0]}, 8'h08);
      chk("and_valid", {7'h0, uio_out[7]}, 8'h01);

      // Switch to XOR via strobe
      strobe_pulse(3'd2);
      chk("xor_opreg", {5'h0, uio_out[6:4]}, 8'h02);
      chk("xor_flush0", {7'h0, uio_out[7]}, 8'h00);
      step();
      chk("xor_flush1", {7'h0, uio_out[7]}, 8'h00);
      step();
      chk("xor_res", {4'h0, uo_out[3:0]}, 8'h06);
      chk("xor_valid", {7'h0, uio_out[7]}, 8'h01);

      // Match counter ramps and saturates
      a = 4'hF; b = 4'hF;
      strobe_pulse(3'd0);
      steps(2);
      chk("cnt_start", {4'h0, uo_out[7:4]}, 8'h00);
      for (int k = 1; k <= 20; k++) begin
         step();
         chk("cnt_ramp", {4'h0, uo_out[7:4]}, 8'((k > 15) ? 15 : k));
      end

      // Strobe edge clears a saturated counter
      strobe_pulse(3'd0);
      chk("clr_sat", {4'h0, uo_out[7:4]}, 8'h00);
      chk("clr_sat_valid", {7'h0, uio_out[7]}, 8'h00);
      steps(2);
      chk("rerun_valid", {7'h0, uio_out[7]}, 8'h01);

      // Edge coincident with an increment from 9: clear wins
      steps(7);
      chk("cnt7", {4'h0, uo_out[7:4]}, 8'h07);
      strb = 1'b1;
      step();
      strb = 1'b0;
      step();
      chk("cnt9", {4'h0, uo_out[7:4]}, 8'h09);
      chk("tail_f", {4'h0, uo_out[3:0]}, 8'h0F);
      step();
      chk("clr_prio", {4'h0, uo_out[7:4]}, 8'h00);
      chk("clr_prio_flush", {7'h0, uio_out[7]}, 8'h00);
      steps(2);
      steps(3);
      chk("pre_hold_cnt", {4'h0, uo_out[7:4]}, 8'h03);

      // Freeze with ena low while inputs toggle
      ena = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a = 4'($urandom); b = 4'($urandom); op = 3'($urandom); strb = ~strb;
         step();
         chk("hold_uo", uo_out, 8'h3F);
         chk("hold_uio", uio_out, 8'h80);
      end
      ena = 1'b1; strb = 1'b0; op = 3'd0; a = 4'hF; b = 4'hF;
      steps(2);
      chk("resume_cnt", {4'h0, uo_out[7:4]}, 8'h05);

      // Asynchronous reset mid-flush with PASS loaded
      a = 4'hC; b = 4'hA;
      strobe_pulse(3'd7);
      chk("pass_opreg", {5'h0, uio_out[6:4]}, 8'h07);
      step();
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_uo", uo_out, 8'h00);
      chk("arst_uio", uio_out, 8'h00);
      chk("arst_oe", uio_oe, 8'hF0);
      m_reset();
      op = 3'd0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      chk("post_rst_flush", {7'h0, uio_out[7]}, 8'h00);
      step();
      chk("post_rst_res", {4'h0, uo_out[3:0]}, 8'h08);
      chk("post_rst_valid", {7'h0, uio_out[7]}, 8'h01);
      chk("post_rst_op", {5'h0, uio_out[6:4]}, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tt_um_gate_lab.md
TT_UM_GATE_LAB -- requirements
Module: tt_um_gate_lab

Interface
REQ-001 Parameter PIPE_DEPTH, default 2, SHALL set result pipeline register count (legal 1..4).
REQ-002 Parameter CNT_W, default 4, SHALL set match-counter width (fixed at 4 by pin budget).
REQ-003 clk  input  1  SHALL be the single clock; all flops rise-edge.
REQ-004 rst_n  input  1  SHALL be reset, asynchronous, active-low.
REQ-005 ena  input  1  SHALL be the design-select enable; 0 = hold all state.
REQ-006 ui_in  input  8  SHALL carry operand A = ui_in[3:0] and operand B = ui_in[7:4].
REQ-007 uio_in  input  8  SHALL carry op code = uio_in[2:0] and load strobe = uio_in[3]; uio_in[7:4] SHALL be ignored.
REQ-008 uo_out  output  8  SHALL carry result = uo_out[3:0] and match count = uo_out[7:4].
REQ-009 uio_out  output  8  SHALL carry {valid, op_reg} on uio_out[7:4]; uio_out[3:0] SHALL be 0.
REQ-010 uio_oe  output  8  SHALL be constant 8'hF0.

Function
REQ-011 Op encoding SHALL be: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 A&~B, 7 PASS A; all bitwise over 4 lanes.
REQ-012 Strobe and op bits SHALL pass through a 2-flop synchroniser; rising edge detected from synchroniser output vs. one further delayed copy.
REQ-013 On detected strobe rising edge, op_reg SHALL load the synchronised op bits; op_reg update occurs on the 3rd rising clk edge after strobe is first sampled high.
REQ-014 Op bits SHALL be held stable by the driver for >= 3 cycles around the strobe; level-high strobe SHALL NOT reload.
REQ-015 Combinational f(op_reg, A, B) SHALL feed a PIPE_DEPTH-stage register chain; uo_out[3:0] = chain tail; latency A/B -> uo_out = PIPE_DEPTH enabled edges.
REQ-016 FSM states FLUSH and RUN: FLUSH counts PIPE_DEPTH enabled cycles then -> RUN; strobe edge in any state -> FLUSH with flush count cleared.
REQ-017 valid (uio_out[7]) SHALL be 1 only in RUN.
REQ-018 Match counter SHALL increment by 1 on each enabled cycle in RUN with tail == 4'hF; SHALL saturate at 15, no wrap.
REQ-019 Strobe edge SHALL clear match counter; strobe edge SHALL take priority over a simultaneous increment.
REQ-020 ena = 0 SHALL freeze synchroniser, edge detector, op_reg, pipeline, FSM and counter; outputs SHALL hold last values.
REQ-021 Strobe edge during FLUSH SHALL restart FLUSH from count 0 with new op_reg.

Reset
REQ-022 rst_n low SHALL asynchronously clear all flops: pipeline 0, counter 0, synchroniser 0, op_reg 0 (AND).
REQ-023 Reset state SHALL be FLUSH with count 0, so after release the block acts as a PIPE_DEPTH-latency AND gate with valid rising after PIPE_DEPTH enabled edges.
REQ-024 Reset values: uo_out = 8'h00, uio_out = 8'h00, uio_oe = 8'hF0.
REQ-025 Reset mid-operation SHALL abandon flush/counter state with no partial update.

Structure
REQ-026 Package gate_lab_pkg SHALL hold the op-code enum, lane width (4), state enum and PIPE_DEPTH legal bounds.
REQ-027 Sub-module gate_lab_pipe SHALL implement the parametrised enabled delay line (WIDTH, DEPTH, async active-low reset).
REQ-028 Top SHALL hold synchroniser, edge detect, op decode, FSM and counter.

Verification
REQ-029 Reset, ena=1, A=4'hC, B=4'hA, no strobe -> uo_out[3:0]=4'h8 after 2 edges; valid=1 after 2 edges.
REQ-030 Strobe with op=2 (XOR), A=4'hC, B=4'hA -> op_reg=2 on 3rd edge; valid=0 for 2 cycles; then uo_out[3:0]=4'h6, valid=1.
REQ-031 op=0, A=B=4'hF held 20 cycles in RUN -> uo_out[7:4] counts 1..15, stays 15.
REQ-032 Counter at 9, strobe edge coincident with tail=4'hF -> counter=0, state FLUSH.
REQ-033 ena=0 for 5 cycles while A/B/strobe toggle -> uo_out, uio_out unchanged; resume with ena=1 continues from held state.
REQ-034 rst_n pulsed low mid-FLUSH with op=7 -> outputs 8'h00 immediately; op_reg=0, flush restarts.
